// File: rtl/int_div_pkg.sv
// rtl/int_div_pkg.sv - shared types, message field positions and sizing helpers for int_div_iterative
package int_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_NBITS = 32;

  // Field positions for the default width; the functions below give the same for any width.
  localparam int SIGN_BIT     = 2 * DIV_NBITS;
  localparam int DIVIDEND_MSB = 2 * DIV_NBITS - 1;
  localparam int DIVIDEND_LSB = DIV_NBITS;
  localparam int DIVISOR_MSB  = DIV_NBITS - 1;
  localparam int DIVISOR_LSB  = 0;
  localparam int CNT_W        = $clog2(DIV_NBITS);

  function automatic int sign_bit_pos(input int nbits);
    return 2 * nbits;
  endfunction

  function automatic int dividend_lsb_pos(input int nbits);
    return nbits;
  endfunction

  function automatic int cnt_width(input int nbits);
    return (nbits <= 2) ? 1 : $clog2(nbits);
  endfunction

endpackage

// File: rtl/int_div_dpath.sv
// rtl/int_div_dpath.sv - restoring divider datapath: operand capture, shift/subtract step, sign fix-up
// The remainder register carries one extra bit so the shifted partial remainder never loses its carry.
module int_div_dpath
  import int_div_pkg::*;
#(
  parameter int p_nbits = DIV_NBITS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic               is_signed,
  input  logic [p_nbits-1:0] dividend,
  input  logic [p_nbits-1:0] divisor,
  output logic               last_step,
  output logic [p_nbits-1:0] quotient,
  output logic [p_nbits-1:0] remainder
);

  localparam int CW = cnt_width(p_nbits);
  localparam logic [CW-1:0] LAST_CNT = CW'(p_nbits - 1);

  logic [p_nbits:0]   rem_q, rem_d;
  logic [p_nbits-1:0] quo_q, quo_d;
  logic [p_nbits-1:0] dsr_q, dsr_d;
  logic [p_nbits-1:0] dvd_q, dvd_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_q, dbz_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               dividend_neg;
  logic               divisor_neg;
  logic [p_nbits-1:0] dividend_mag;
  logic [p_nbits-1:0] divisor_mag;
  logic               divisor_zero;
  logic [p_nbits:0]   rem_shift;
  logic [p_nbits-1:0] quo_shift;
  logic [p_nbits:0]   diff;
  logic [p_nbits-1:0] quo_fix;
  logic [p_nbits-1:0] rem_fix;

  // Magnitudes: negating the most-negative value wraps to itself, which is 2^(n-1) read unsigned.
  always_comb begin
    dividend_neg = is_signed & dividend[p_nbits-1];
    divisor_neg  = is_signed & divisor[p_nbits-1];
    dividend_mag = dividend_neg ? (~dividend + 1'b1) : dividend;
    divisor_mag  = divisor_neg ? (~divisor + 1'b1) : divisor;
    divisor_zero = (divisor == '0);
  end

  always_comb begin
    rem_shift = {rem_q[p_nbits-1:0], quo_q[p_nbits-1]};
    quo_shift = {quo_q[p_nbits-2:0], 1'b0};
    diff      = rem_shift - {1'b0, dsr_q};
  end

  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    dvd_d     = dvd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    cnt_d     = cnt_q;
    if (load) begin
      rem_d     = '0;
      quo_d     = dividend_mag;
      dsr_d     = divisor_mag;
      dvd_d     = dividend;
      neg_quo_d = dividend_neg ^ divisor_neg;
      neg_rem_d = dividend_neg;
      dbz_d     = divisor_zero;
      cnt_d     = '0;
    end else if (step) begin
      if (!diff[p_nbits]) begin
        rem_d = diff;
        quo_d = quo_shift | {{(p_nbits-1){1'b0}}, 1'b1};
      end else begin
        rem_d = rem_shift;
        quo_d = quo_shift;
      end
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      dvd_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      dvd_q     <= dvd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      cnt_q     <= cnt_d;
    end
  end

  // Divide-by-zero bypasses the sign fix-up entirely and returns the dividend as given.
  always_comb begin
    last_step = (cnt_q == LAST_CNT);
    quo_fix   = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix   = neg_rem_q ? (~rem_q[p_nbits-1:0] + 1'b1) : rem_q[p_nbits-1:0];
    quotient  = dbz_q ? '1 : quo_fix;
    remainder = dbz_q ? dvd_q : rem_fix;
  end

endmodule

// File: rtl/int_div_iterative.sv
// rtl/int_div_iterative.sv - iterative restoring integer divider with val/rdy request and response streams
// Control FSM and handshakes; one quotient bit is produced per CALC cycle by int_div_dpath.
module int_div_iterative
  import int_div_pkg::*;
#(
  parameter int p_nbits = DIV_NBITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 istream_val,
  output logic                 istream_rdy,
  input  logic [2*p_nbits:0]   istream_msg,
  output logic                 ostream_val,
  input  logic                 ostream_rdy,
  output logic [2*p_nbits-1:0] ostream_msg
);

  localparam int SIGN_POS = sign_bit_pos(p_nbits);
  localparam int DVD_LSB  = dividend_lsb_pos(p_nbits);

  div_state_t state_q, state_d;

  logic               load;
  logic               step;
  logic               last_step;
  logic               req_signed;
  logic [p_nbits-1:0] req_dividend;
  logic [p_nbits-1:0] req_divisor;
  logic [p_nbits-1:0] quotient;
  logic [p_nbits-1:0] remainder;

  always_comb begin
    req_signed   = istream_msg[SIGN_POS];
    req_dividend = istream_msg[DVD_LSB +: p_nbits];
    req_divisor  = istream_msg[0 +: p_nbits];
  end

  always_comb begin
    state_d     = state_q;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    case (state_q)
      IDLE: begin
        istream_rdy = 1'b1;
        if (istream_val) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ostream_val = 1'b1;
        if (ostream_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  int_div_dpath #(
    .p_nbits (p_nbits)
  ) u_dpath (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .step      (step),
    .is_signed (req_signed),
    .dividend  (req_dividend),
    .divisor   (req_divisor),
    .last_step (last_step),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Response is only driven while it is being offered, so the bus reads zero at reset and between results.
  always_comb begin
    ostream_msg = (state_q == DONE) ? {quotient, remainder} : '0;
  end

endmodule

// File: tb/tb_int_div_iterative.sv
// tb/tb_int_div_iterative.sv - self-checking bench: directed vector table, corner sequences, randomized scoreboard
module tb_int_div_iterative;

  localparam int N = 32;
  localparam int NRAND = 60;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          istream_val;
  logic          istream_rdy;
  logic [2*N:0]  istream_msg;
  logic          ostream_val;
  logic          ostream_rdy;
  logic [2*N-1:0] ostream_msg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_div_iterative #(.p_nbits(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_msg (istream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg)
  );

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  // RISC-V M reference written directly from the arithmetic definition.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      5: return 32'(-$urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic send(input logic s, input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    @(negedge clk);
    istream_val = 1'b1;
    istream_msg = {s, a, b};
    #1;
    while (!istream_rdy && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!istream_rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=rdy_low required=rdy_high");
    end
    @(posedge clk);
    #1;
    istream_val = 1'b0;
    istream_msg = {1'b1, $urandom, $urandom};
  endtask

  // lat counts the accept edge as 1, so a response visible after edge accept+N reads N+1.
  task automatic recv(output logic [63:0] m, output int lat);
    lat = 1;
    while (!ostream_val && lat <= 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!ostream_val) begin
      checks++;
      errors++;
      $display("FAIL recv_timeout actual=val_low required=val_high");
    end
    m = ostream_msg;
    @(negedge clk);
    ostream_rdy = 1'b1;
    @(posedge clk);
    #1;
    ostream_rdy = 1'b0;
  endtask

  vec_t vecs[13];

  initial begin
    logic [63:0] m, snap, exp;
    int lat;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[2]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    vecs[3]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF};
    vecs[4]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    vecs[5]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[6]  = '{1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5};
    vecs[7]  = '{1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB};
    vecs[8]  = '{1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5};
    vecs[9]  = '{1'b0, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0};
    vecs[11] = '{1'b0, 32'd0,         32'd3,         32'd0,         32'd0};
    vecs[12] = '{1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE};

    reset_n     = 1'b0;
    istream_val = 1'b0;
    istream_msg = '0;
    ostream_rdy = 1'b0;
    #1;
    chk("reset_istream_rdy", 64'(istream_rdy), 64'd1);
    chk("reset_ostream_val", 64'(ostream_val), 64'd0);
    chk("reset_ostream_msg", ostream_msg, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i].s, vecs[i].a, vecs[i].b);
      recv(m, lat);
      chk($sformatf("vec%0d_msg", i), m, {vecs[i].q, vecs[i].r});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(N + 1));
    end

    // Backpressure: response must hold steady and no new request may be taken.
    send(1'b0, 32'd1000, 32'd3);
    begin
      int t = 0;
      while (!ostream_val && t < 200) begin
        @(posedge clk);
        #1;
        t++;
      end
    end
    snap = ostream_msg;
    istream_val = 1'b1;
    istream_msg = {1'b0, 32'd9, 32'd2};
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_msg_stable_%0d", c), ostream_msg, snap);
      chk($sformatf("bp_istream_rdy_%0d", c), 64'(istream_rdy), 64'd0);
      chk($sformatf("bp_ostream_val_%0d", c), 64'(ostream_val), 64'd1);
    end
    istream_val = 1'b0;
    chk("bp_msg_value", snap, {32'd333, 32'd1});
    recv(m, lat);

    // Reset in the middle of a calculation with a new request already waiting.
    send(1'b0, 32'd12345, 32'd10);
    repeat (5) @(posedge clk);
    #2;
    istream_val = 1'b1;
    istream_msg = {1'b1, 32'hFFFF_FFCE, 32'd7};
    reset_n = 1'b0;
    #1;
    chk("midcalc_reset_istream_rdy", 64'(istream_rdy), 64'd1);
    chk("midcalc_reset_ostream_val", 64'(ostream_val), 64'd0);
    chk("midcalc_reset_ostream_msg", ostream_msg, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    istream_val = 1'b0;
    recv(m, lat);
    chk("post_reset_msg", m, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    chk("post_reset_latency", 64'(lat), 64'(N + 1));

    // Randomized back-to-back traffic with random response readiness.
    begin
      logic [63:0] sb[$];
      int sent = 0, got = 0, cyc = 0;
      logic acc, rsp;
      logic [63:0] rmsg;
      logic [64:0] imsg;
      while (got < NRAND && cyc < 20000) begin
        @(negedge clk);
        if (!istream_val && sent < NRAND && $urandom_range(0, 3) != 0) begin
          istream_msg = {1'($urandom_range(0, 1)), pick_operand(), pick_operand()};
          istream_val = 1'b1;
        end
        ostream_rdy = 1'($urandom_range(0, 1));
        #1;
        acc  = istream_val & istream_rdy;
        rsp  = ostream_val & ostream_rdy;
        rmsg = ostream_msg;
        imsg = istream_msg;
        @(posedge clk);
        #1;
        if (acc) begin
          sb.push_back(ref_div(imsg[64], imsg[63:32], imsg[31:0]));
          sent++;
          istream_val = 1'b0;
        end
        if (rsp) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rand_unexpected_response actual=%h required=none", rmsg);
          end else begin
            exp = sb.pop_front();
            chk($sformatf("rand_%0d", got), rmsg, exp);
          end
          got++;
        end
        cyc++;
      end
      ostream_rdy = 1'b0;
      istream_val = 1'b0;
      chk("rand_responses", 64'(got), 64'(NRAND));
      chk("rand_scoreboard_empty", 64'(sb.size()), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
